mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 6 +
 rtl/arb_streak_cnt.sv | 22 ++
 rtl/mem_port_arbiter.sv | 70 +++++++
 tb/tb_mem_port_arbiter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the memory port arbiter
package mem_arb_pkg;
    localparam int MEM_AW_DEF          = 8;
    localparam int MAX_DATA_STREAK_DEF = 4;
    typedef enum logic [1:0] {RSP_NONE, RSP_IF, RSP_D} rsp_e;
endpackage

// File: rtl/arb_streak_cnt.sv
// arb_streak_cnt: saturating count of consecutive data wins on a conflict
//   inc    - count one more conflict won by the data port (ignored at max)
//   clr    - restart the streak (IF port was granted)
//   at_max - streak has reached MAX, IF must win the next conflict
module arb_streak_cnt #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);
    localparam int CW = MAX > 0 ? $clog2(MAX + 1) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    assign at_max = cnt_q == CW'(MAX);
    assign cnt_d  = clr ? '0 : (inc && !at_max) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between IF and data requesters
//   if_req/if_addr -> if_gnt, stall_if, if_rvalid/if_rdata (read one cycle later)
//   d_req/d_we/d_addr/d_wdata -> d_gnt, d_rvalid/d_rdata, d_err (pulse, rejected access)
//   mem_en/mem_we/mem_addr/mem_wdata -> memory strobe; mem_rdata valid the cycle after a read
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_STREAK = MAX_DATA_STREAK_DEF,
    parameter int MEM_AW          = MEM_AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              stall_if
);
    logic d_ill, d_win, if_win, at_max, err_q, err_d;
    rsp_e rsp_q, rsp_d;
    // An illegal data access is acknowledged without touching memory, so the IF port may use it.
    assign d_ill  = d_req && (d_addr[1:0] != 2'b00 || d_addr[31:MEM_AW+2] != '0);
    assign d_win  = !reset && d_req && !d_ill && (!if_req || !at_max);
    assign if_win = !reset && if_req && !d_win;
    assign if_gnt    = if_win;
    assign d_gnt     = d_win || (!reset && d_ill);
    assign mem_en    = d_win || if_win;
    assign mem_we    = d_win && d_we;
    assign mem_addr  = d_win ? d_addr[MEM_AW+1:2] : if_win ? if_addr[MEM_AW+1:2] : '0;
    assign mem_wdata = reset ? '0 : d_wdata;
    assign stall_if  = !reset && if_req && !if_win;
    assign rsp_d = if_win ? RSP_IF : (d_win && !d_we) ? RSP_D : RSP_NONE;
    assign err_d = !reset && d_ill;
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_q <= RSP_NONE;
            err_q <= 1'b0;
        end else begin
            rsp_q <= rsp_d;
            err_q <= err_d;
        end
    end
    assign if_rvalid = !reset && rsp_q == RSP_IF;
    assign d_rvalid  = !reset && rsp_q == RSP_D;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;
    assign d_err     = !reset && err_q;
    // Only a data win on a real conflict extends the streak; any IF grant ends it.
    arb_streak_cnt #(.MAX(MAX_DATA_STREAK)) u_streak (
        .clk   (clk),
        .reset (reset),
        .inc   (d_win && if_req),
        .clr   (if_win),
        .at_max(at_max)
    );
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int AW   = 8;
    localparam int MAXS = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic [31:0] mem_rdata = '0;
    logic if_gnt, if_rvalid, d_gnt, d_rvalid, d_err, mem_en, mem_we, stall_if;
    logic [31:0] if_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    typedef struct packed {
        logic        ifv;
        logic        dv;
        logic        err;
        logic [31:0] data;
    } rsp_t;
    rsp_t q[$];
    int n_chk = 0;
    int n_fail = 0;
    int streak = 0;
    logic [31:0] mem [256];

    mem_port_arbiter #(.MAX_DATA_STREAK(MAXS), .MEM_AW(AW)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall_if(stall_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + 32'(i) * 32'h0001_0101;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic ifr, input logic [31:0] ifa,
                        input logic dr, input logic dwe, input logic [31:0] da, input logic [31:0] dwd);
        rsp_t e;
        logic ill, dwin, ifwin;
        logic [AW-1:0] a;
        @(posedge clk);
        #1;
        reset = rst; if_req = ifr; if_addr = ifa; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
        @(negedge clk);
        e = '0;
        if (q.size() > 0) e = q.pop_front();
        if (rst) e = '0;
        check("if_rvalid", 32'(if_rvalid), 32'(e.ifv));
        check("d_rvalid", 32'(d_rvalid), 32'(e.dv));
        check("d_err", 32'(d_err), 32'(e.err));
        check("if_rdata", if_rdata, e.ifv ? e.data : 32'h0);
        check("d_rdata", d_rdata, e.dv ? e.data : 32'h0);
        ill   = da[1:0] != 2'b00 || da[31:AW+2] != '0;
        dwin  = !rst && dr && !ill && (!ifr || streak < MAXS);
        ifwin = !rst && ifr && !dwin;
        check("if_gnt", 32'(if_gnt), 32'(ifwin));
        check("d_gnt", 32'(d_gnt), 32'(!rst && dr && (ill || dwin)));
        check("mem_en", 32'(mem_en), 32'(dwin || ifwin));
        check("mem_we", 32'(mem_we), 32'(dwin && dwe));
        check("stall_if", 32'(stall_if), 32'(!rst && ifr && !ifwin));
        a = dwin ? da[AW+1:2] : ifa[AW+1:2];
        if (dwin || ifwin) check("mem_addr", 32'(mem_addr), 32'(a));
        else if (rst)      check("mem_addr_rst", 32'(mem_addr), 32'h0);
        if (dwin && dwe)   check("mem_wdata", mem_wdata, dwd);
        if (rst || ifwin)     streak = 0;
        else if (dwin && ifr) streak++;
        e.ifv  = ifwin;
        e.dv   = dwin && !dwe;
        e.err  = !rst && dr && ill;
        e.data = (ifwin || dwin) ? mem[a] : 32'h0;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'h8, 32'h0);
        step(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
        check("if_only_addr", 32'(mem_addr), 32'h4);
        idle(1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 32'h40, 32'h0);
            check("conflict_pattern", 32'(d_gnt), 32'((i % 5) != 4));
        end
        idle(1);
        step(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h6, 32'h0);
        check("illegal_both_gnt", 32'({d_gnt, if_gnt}), 32'h3);
        idle(1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h6, 32'h0);
        idle(1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3FC, 32'hDEADBEEF);
        check("write_addr", 32'(mem_addr), 32'hFF);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h3FC, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h400, 32'h0);
        check("readback", d_rdata, 32'hDEADBEEF);
        idle(1);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 32'h80, 1'b1, 1'b0, 32'h84, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h88, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h80, 1'b1, 1'b0, 32'h84, 32'h0);
        for (int i = 0; i < 60; i++) begin
            logic [31:0] ia, da;
            ia = {22'h0, 8'($urandom), 2'b00};
            da = {22'h0, 8'($urandom), 2'b00};
            if ($urandom_range(0, 7) == 0) da = da | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) da = da | 32'h0000_0400;
            step(1'b0, 1'($urandom), ia, 1'($urandom), 1'($urandom_range(0, 3) == 0), da, $urandom);
        end
        step(1'b0, 1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b1, 32'h34, 1'b1, 1'b0, 32'h38, 32'h0);
        idle(1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h50, 1'b1, 1'b0, 32'h54, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h58, 32'h0);
        step(1'b1, 1'b1, 32'h50, 1'b1, 1'b0, 32'h54, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 32'h50, 1'b1, 1'b0, 32'h54, 32'h0);
            check("streak_restart", 32'(d_gnt), 32'(i < 4));
        end
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
